// File: rtl/axis_video_packer.sv
// axis_video_packer: turns the raster pixel stream (x, y, video_on, RGB444) into
// an AXI4-Stream RGB888 master with tuser = start of frame and tlast = end of line.
// A small FIFO absorbs short tready stalls; a resync FSM guarantees that only whole
// frames starting with tuser are emitted after reset or after an overflow.
module axis_video_packer #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned FIFO_DEPTH = 4   // power of two, >= 2
) (
  input  logic                        pixel_clk,
  input  logic                        reset,
  input  logic                        video_on,
  input  logic [9:0]                  pixel_x,
  input  logic [9:0]                  pixel_y,
  input  logic [11:0]                 rgb_in,
  output logic [23:0]                 m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tuser,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic                        overflow,
  output logic [15:0]                 drop_count,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [9:0]       H_LIM    = 10'(H_VISIBLE);
  localparam logic [9:0]       V_LIM    = 10'(V_VISIBLE);
  localparam logic [9:0]       H_LAST   = 10'(H_VISIBLE - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [15:0]      DROP_MAX = 16'hFFFF;

  // One FIFO entry: sideband flags travel with the pixel data.
  typedef struct packed {
    logic        tuser;
    logic        tlast;
    logic [23:0] tdata;
  } beat_t;

  typedef enum logic [1:0] {
    ST_WAIT_SOF = 2'd0,
    ST_STREAM   = 2'd1,
    ST_RESYNC   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  beat_t              r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_count;
  logic               r_overflow;
  logic [15:0]        r_drop_count;

  logic               w_qual;
  logic               w_sof;
  beat_t              w_entry;
  logic               w_full;
  logic               w_pop;
  logic               w_space;
  logic               w_push;
  logic               w_drop;

  // Pixel qualification and RGB444 -> RGB888 expansion, packed as {R8, B8, G8}.
  always_comb begin
    w_qual        = video_on && (pixel_x < H_LIM) && (pixel_y < V_LIM);
    w_sof         = (pixel_x == 10'd0) && (pixel_y == 10'd0);
    w_entry.tuser = w_sof;
    w_entry.tlast = (pixel_x == H_LAST);
    w_entry.tdata = {rgb_in[11:8], rgb_in[11:8],
                     rgb_in[3:0],  rgb_in[3:0],
                     rgb_in[7:4],  rgb_in[7:4]};
  end

  // FIFO status; a pop frees a slot in the same cycle, so full+pop still accepts.
  always_comb begin
    w_full  = (r_count == LVL_FULL);
    w_pop   = (r_count != '0) && m_axis_tready;
    w_space = !w_full || w_pop;
  end

  // Frame resync FSM: state register.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      r_state <= ST_WAIT_SOF;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame resync FSM: next state, push and drop decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      // Both wait for a fresh frame start; they differ only in how they were entered.
      ST_WAIT_SOF,
      ST_RESYNC: begin
        if (w_qual && w_sof && w_space) begin
          w_push      = 1'b1;
          w_state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (w_qual) begin
          if (w_space) begin
            w_push = 1'b1;
          end else begin
            w_drop      = 1'b1;
            w_state_nxt = ST_RESYNC;
          end
        end
      end
      default: begin
        w_state_nxt = ST_WAIT_SOF;
      end
    endcase
  end

  // FIFO storage and pointers; reset also abandons any beat in flight.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LVL_W'(1);
        2'b01:   r_count <= r_count - LVL_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag and saturating count of aborted frames.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != DROP_MAX) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  // Head of FIFO drives the stream; it only changes on a pop, so it holds while stalled.
  assign m_axis_tvalid = (r_count != '0);
  assign m_axis_tdata  = r_mem[r_rd_ptr].tdata;
  assign m_axis_tuser  = r_mem[r_rd_ptr].tuser;
  assign m_axis_tlast  = r_mem[r_rd_ptr].tlast;
  assign overflow      = r_overflow;
  assign drop_count    = r_drop_count;
  assign fifo_level    = r_count;

endmodule

// File: tb/tb_axis_video_packer.sv
// Directed bench for axis_video_packer on a reduced raster (16x12 visible, 20x15 total)
// so every scenario fits in a few thousand cycles.
module tb_axis_video_packer;

  localparam int H  = 16;
  localparam int V  = 12;
  localparam int HT = 20;
  localparam int VT = 15;

  typedef struct packed {
    logic        tuser;
    logic        tlast;
    logic [23:0] tdata;
  } beat_t;

  logic        pixel_clk;
  logic        reset;
  logic        video_on;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [11:0] rgb_in;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        overflow;
  logic [15:0] drop_count;
  logic [2:0]  fifo_level;

  axis_video_packer #(
    .H_VISIBLE  (H),
    .V_VISIBLE  (V),
    .FIFO_DEPTH (4)
  ) dut (
    .pixel_clk     (pixel_clk),
    .reset         (reset),
    .video_on      (video_on),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .rgb_in        (rgb_in),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .fifo_level    (fifo_level)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cx = 0, cy = 0, fr = 0;
  logic  rst_req = 1'b1;
  int    keep_from = 1;
  beat_t exp_q[$];
  int    beats_f [8];
  int    tuser_f [8];
  int    tlast_f [8];
  int    blank_viol = 0;
  int    max_lvl2 = 0;
  logic  prev_q = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (frame %0d x %0d y %0d)", tag, got, exp, fr, cx, cy);
    end
  endtask

  function automatic logic [23:0] expand(input logic [11:0] c);
    return {c[11:8], c[11:8], c[3:0], c[3:0], c[7:4], c[7:4]};
  endfunction

  function automatic logic [11:0] pix_rgb(input int f, input int x, input int y);
    if (f == 1 && x == 5 && y == 3) return 12'hF80;
    if (f == 2 && x == 5 && y == 3) return 12'h123;
    return {4'(f), 4'(y), 4'(x)};
  endfunction

  function automatic logic ready_at(input int f, input int x, input int y);
    if (f == 2 && y == 4 && x < 3) return 1'b0;
    if (f == 3 && y == 6 && x < 4) return 1'b0;
    if (f == 4 && y == 10 && x >= 2 && x < 12) return 1'b0;
    if (f == 6 && y == 2 && x < 5) return 1'b0;
    return 1'b1;
  endfunction

  // Pixels the downstream must eventually see (hand-derived per scenario).
  function automatic logic keep(input int f, input int x, input int y);
    if (f < keep_from) return 1'b0;
    if (f == 4 && (y > 10 || (y == 10 && x > 4))) return 1'b0;
    return 1'b1;
  endfunction

  // Drive one raster position, observe the handshake for this edge, then clock.
  task automatic step();
    beat_t e;
    logic  q;
    q             = (cx < H) && (cy < V);
    video_on      = q;
    pixel_x       = 10'(cx);
    pixel_y       = 10'(cy);
    rgb_in        = pix_rgb(fr, cx, cy);
    m_axis_tready = ready_at(fr, cx, cy);
    reset         = rst_req;
    if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
      if (fr < 8) begin
        beats_f[fr]++;
        if (m_axis_tuser) tuser_f[fr]++;
        if (m_axis_tlast) tlast_f[fr]++;
      end
      if (exp_q.size() == 0) begin
        check("beat_unexpected", 32'(m_axis_tvalid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("beat_tdata", 32'(m_axis_tdata), 32'(e.tdata));
        check("beat_tuser", 32'(m_axis_tuser), 32'(e.tuser));
        check("beat_tlast", 32'(m_axis_tlast), 32'(e.tlast));
      end
    end
    if (fr == 1 && m_axis_tvalid === 1'b1 && !prev_q) blank_viol++;
    if (fr == 2 && int'(fifo_level) > max_lvl2) max_lvl2 = int'(fifo_level);
    if (q && !rst_req && keep(fr, cx, cy)) begin
      e.tuser = (cx == 0 && cy == 0);
      e.tlast = (cx == H - 1);
      if (fr == 1 && cx == 5 && cy == 3)      e.tdata = 24'hFF0088;
      else if (fr == 2 && cx == 5 && cy == 3) e.tdata = 24'h113322;
      else                                    e.tdata = expand(pix_rgb(fr, cx, cy));
      exp_q.push_back(e);
    end
    prev_q = q && !rst_req;
    @(posedge pixel_clk);
    #1;
    cx++;
    if (cx == HT) begin
      cx = 0;
      cy++;
      if (cy == VT) begin
        cy = 0;
        fr++;
      end
    end
  endtask

  task automatic run_to(input int f, input int y, input int x);
    int n;
    n = 0;
    while (!(fr == f && cy == y && cx == x)) begin
      step();
      n++;
      if (n > 4000) begin
        check("run_to_timeout", 32'(n), 32'd0);
        return;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      beats_f[i] = 0;
      tuser_f[i] = 0;
      tlast_f[i] = 0;
    end
    reset         = 1'b1;
    video_on      = 1'b0;
    pixel_x       = '0;
    pixel_y       = '0;
    rgb_in        = '0;
    m_axis_tready = 1'b1;

    // Reset values after the first clock edge with reset asserted.
    step();
    check("rst_tvalid",     32'(m_axis_tvalid), 32'd0);
    check("rst_tdata",      32'(m_axis_tdata),  32'd0);
    check("rst_tuser",      32'(m_axis_tuser),  32'd0);
    check("rst_tlast",      32'(m_axis_tlast),  32'd0);
    check("rst_overflow",   32'(overflow),      32'd0);
    check("rst_drop_count", 32'(drop_count),    32'd0);
    check("rst_fifo_level", 32'(fifo_level),    32'd0);

    // Release reset mid-frame at (8,5): nothing until the next frame start.
    run_to(0, 5, 8);
    rst_req = 1'b0;
    run_to(1, 0, 0);
    check("midframe_no_beats", 32'(beats_f[0]), 32'd0);

    // Frame 1: clean raster with tready high, colour F80 at (5,3).
    run_to(2, 0, 0);
    check("f1_beats",      32'(beats_f[1]),   32'd192);
    check("f1_tuser",      32'(tuser_f[1]),   32'd1);
    check("f1_tlast",      32'(tlast_f[1]),   32'd12);
    check("f1_blank_viol", 32'(blank_viol),   32'd0);
    check("f1_overflow",   32'(overflow),     32'd0);
    check("f1_pending",    32'(exp_q.size()), 32'd0);

    // Frame 2: colour 123 and a 3-cycle stall at the start of line 4.
    run_to(2, 4, 3);
    check("stall3_level", 32'(fifo_level), 32'd3);
    run_to(2, 4, 10);
    check("stall3_level_hold", 32'(fifo_level), 32'd3);
    run_to(3, 0, 0);
    check("stall3_max_level", 32'(max_lvl2),     32'd3);
    check("stall3_overflow",  32'(overflow),     32'd0);
    check("f2_beats",         32'(beats_f[2]),   32'd192);
    check("f2_pending",       32'(exp_q.size()), 32'd0);

    // Frame 3: fill the FIFO, then push and pop together while full.
    run_to(3, 6, 4);
    check("full_level", 32'(fifo_level), 32'd4);
    run_to(3, 6, 5);
    check("full_pushpop_level",    32'(fifo_level),    32'd4);
    check("full_pushpop_overflow", 32'(overflow),      32'd0);
    check("full_pushpop_tvalid",   32'(m_axis_tvalid), 32'd1);
    run_to(4, 0, 0);
    check("f3_beats",    32'(beats_f[3]),   32'd192);
    check("f3_overflow", 32'(overflow),     32'd0);
    check("f3_pending",  32'(exp_q.size()), 32'd0);

    // Frame 4: 10-cycle stall on line 10 overflows; only queued beats drain.
    run_to(4, 10, 5);
    check("ovf_pre_level", 32'(fifo_level), 32'd4);
    check("ovf_pre_flag",  32'(overflow),   32'd0);
    run_to(4, 10, 6);
    check("ovf_flag",  32'(overflow),   32'd1);
    check("ovf_drops", 32'(drop_count), 32'd1);
    check("ovf_level", 32'(fifo_level), 32'd4);
    run_to(5, 0, 0);
    check("f4_beats",   32'(beats_f[4]),   32'd165);
    check("f4_tlast",   32'(tlast_f[4]),   32'd10);
    check("f4_level",   32'(fifo_level),   32'd0);
    check("f4_pending", 32'(exp_q.size()), 32'd0);

    // Frame 5: complete frame after resync.
    run_to(6, 0, 0);
    check("f5_beats",    32'(beats_f[5]),   32'd192);
    check("f5_tuser",    32'(tuser_f[5]),   32'd1);
    check("f5_drops",    32'(drop_count),   32'd1);
    check("f5_overflow", 32'(overflow),     32'd1);
    check("f5_pending",  32'(exp_q.size()), 32'd0);

    // Frame 6: reset with beats queued; they are abandoned.
    run_to(6, 2, 3);
    check("rst2_pre_level",  32'(fifo_level),    32'd3);
    check("rst2_pre_tvalid", 32'(m_axis_tvalid), 32'd1);
    exp_q.delete();
    keep_from = 7;
    rst_req   = 1'b1;
    step();
    rst_req   = 1'b0;
    check("rst2_tvalid",   32'(m_axis_tvalid), 32'd0);
    check("rst2_level",    32'(fifo_level),    32'd0);
    check("rst2_overflow", 32'(overflow),      32'd0);
    check("rst2_drops",    32'(drop_count),    32'd0);

    // Frame 7: fresh complete frame.
    run_to(8, 0, 0);
    check("f7_beats",   32'(beats_f[7]),   32'd192);
    check("f7_tuser",   32'(tuser_f[7]),   32'd1);
    check("f7_tlast",   32'(tlast_f[7]),   32'd12);
    check("f7_pending", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
